// File: rtl/pwr_harness_sram_gen.sv
// Power-estimation harness: NCH independent single-port SRAM channels, each
// fed by its own 16-bit LFSR. A run controller sequences an optional preload
// pass and a measured activity window. Access density inside the window is
// set by a duty cycle in sixteenths, and the harness counts strobed cycles.
// Host logic pulses start, watches busy/done and reads access_count while
// board-level power is measured.
module pwr_harness_sram_gen #(
  parameter int NCH     = 32,  // channel count (1..65535)
  parameter int AW      = 10,  // per-channel RAM address width (1..16)
  parameter int DW      = 18,  // per-channel RAM data width (1..32)
  parameter int PRELOAD = 1    // 1: write every address once before RUN
) (
  input  logic             clk100m,
  input  logic             rstn,
  input  logic [NCH-1:0]   pwr_en_in,
  input  logic [NCH-1:0]   opt_en_in,
  input  logic [4:0]       duty_in,
  input  logic [31:0]      window_cycles,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [31:0]      access_count,
  output logic [NCH-1:0]   dummy_out
);

  // Controller states (legacy-compatible encoding).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRELOAD = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int         DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] PCNT_LAST = '1;

  // One Galois-free Fibonacci step of the 16-bit stimulus LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // 32-bit stimulus word; callers keep the DW LSBs as write data.
  function automatic logic [31:0] stim_word(input logic [15:0] l);
    return {l, l} ^ {16'h0, l[14:0], l[15]};
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [NCH-1:0]  pwr_en_q;
  logic [NCH-1:0]  opt_en_q;
  logic [AW-1:0]   pcnt;        // preload address
  logic [31:0]     rcnt;        // RUN cycle index
  logic [31:0]     win;         // latched window length, never 0
  logic [3:0]      dcnt;        // duty phase, wraps every 16 RUN cycles
  logic [15:0]     lfsr [NCH];

  logic [4:0]      duty_sat;
  logic            start_ok;
  logic            pre_act;     // preload write strobe (before per-channel gating)
  logic            run_act;     // RUN access strobe (before per-channel gating)
  logic            lfsr_adv;
  logic [NCH-1:0]  douta_and;

  // Decode the strobes shared by every channel.
  always_comb begin
    duty_sat = (duty_in > 5'd16) ? 5'd16 : duty_in;
    start_ok = (state == ST_IDLE) && start && !abort;
    // The abort cycle itself performs no RAM access and is not counted.
    pre_act  = (state == ST_PRELOAD) && !abort;
    run_act  = (state == ST_RUN) && !abort && ({1'b0, dcnt} < duty_sat);
    lfsr_adv = (state == ST_PRELOAD) || (state == ST_RUN);
  end

  assign busy = (state == ST_PRELOAD) || (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Next-state logic for the run controller.
  always_comb begin
    // NOTE: state_nxt gets a default before the case so no path through this
    // block leaves it unassigned; otherwise synthesis would infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = (PRELOAD != 0) ? ST_PRELOAD : ST_RUN;
      end
      ST_PRELOAD: begin
        if (abort)                   state_nxt = ST_IDLE;
        else if (pcnt == PCNT_LAST)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                   state_nxt = ST_IDLE;
        else if (rcnt == win - 32'd1) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk100m or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design sees the pre-edge value of every other register.
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // One-cycle input stage for the per-channel enables, active in all states.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      pwr_en_q <= '0;
      opt_en_q <= '0;
    end else begin
      pwr_en_q <= pwr_en_in;
      opt_en_q <= opt_en_in;
    end
  end

  // Window bookkeeping: latch the length on start, step the phase counters.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      win  <= '0;
      pcnt <= '0;
      rcnt <= '0;
      dcnt <= '0;
    end else if (start_ok) begin
      win  <= (window_cycles == 32'd0) ? 32'd1 : window_cycles;
      pcnt <= '0;
      rcnt <= '0;
      dcnt <= '0;
    end else if (state == ST_PRELOAD) begin
      pcnt <= pcnt + 1'b1;
    end else if (state == ST_RUN) begin
      rcnt <= rcnt + 32'd1;
      dcnt <= dcnt + 4'd1;
    end
  end

  // Saturating count of RUN cycles with the access strobe high.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn)                                      access_count <= '0;
    else if (start_ok)                              access_count <= '0;
    else if (run_act && (access_count != 32'hFFFF_FFFF)) access_count <= access_count + 32'd1;
  end

  // Per-channel LFSRs: seeded by channel number, advancing only while busy.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) lfsr[i] <= 16'(i + 1);
    end else if (lfsr_adv) begin
      for (int i = 0; i < NCH; i++) lfsr[i] <= lfsr_next(lfsr[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] douta;
    logic [DW-1:0] wdata;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;

    // Preload writes every enabled channel; RUN writes only in write mode.
    assign en    = (pre_act | run_act) & pwr_en_q[i];
    assign we    = en & (pre_act | opt_en_q[i]);
    assign addr  = (state == ST_PRELOAD) ? pcnt : lfsr[i][AW-1:0];
    assign wdata = DW'(stim_word(lfsr[i]));

    // Read-first single-port RAM; douta holds while the channel is disabled.
    always_ff @(posedge clk100m) begin
      // NOTE: the array and its output register carry no reset so the tools
      // can map them onto block RAM; contents survive rstn.
      if (en) begin
        douta <= mem[addr];
        if (we) mem[addr] <= wdata;
      end
    end

    assign douta_and[i] = &douta;
  end

  // Register the AND-reduction of each channel's read data.
  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) dummy_out <= '0;
    else       dummy_out <= douta_and;
  end

endmodule

// File: tb/tb_pwr_harness_sram_gen.sv
// Self-checking bench for pwr_harness_sram_gen. A behavioural model that tracks
// the window phase, per-channel memories and read registers is compared
// against the DUT every cycle. Directed windows then check the window length,
// the done pulse and the access count against closed-form arithmetic.
module tb_pwr_harness_sram_gen;

  localparam int NCH     = 4;
  localparam int AW      = 4;
  localparam int DW      = 3;
  localparam int PRELOAD = 1;
  localparam int DEPTH   = 1 << AW;

  logic             clk100m = 1'b0;
  logic             rstn    = 1'b0;
  logic [NCH-1:0]   pwr_en_in = '0;
  logic [NCH-1:0]   opt_en_in = '0;
  logic [4:0]       duty_in = '0;
  logic [31:0]      window_cycles = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic [31:0]      access_count;
  logic [NCH-1:0]   dummy_out;

  pwr_harness_sram_gen #(
    .NCH(NCH), .AW(AW), .DW(DW), .PRELOAD(PRELOAD)
  ) dut (
    .clk100m      (clk100m),
    .rstn         (rstn),
    .pwr_en_in    (pwr_en_in),
    .opt_en_in    (opt_en_in),
    .duty_in      (duty_in),
    .window_cycles(window_cycles),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .access_count (access_count),
    .dummy_out    (dummy_out)
  );

  always #5 clk100m = ~clk100m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_PRE, M_RUN, M_DONE} mode_t;

  mode_t       m_mode;
  int unsigned m_pre_idx, m_run_idx, m_win;
  logic [31:0] m_count;
  int unsigned m_lfsr   [NCH];
  int unsigned m_mem    [NCH][DEPTH];
  bit          m_mem_ok [NCH][DEPTH];
  int unsigned m_dout   [NCH];
  bit          m_dout_ok[NCH];
  bit          m_dummy  [NCH];
  bit          m_dummy_ok[NCH];
  bit          m_pwr    [NCH];
  bit          m_opt    [NCH];

  function automatic int unsigned model_lfsr(input int unsigned l);
    int unsigned fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  function automatic int unsigned model_data(input int unsigned l);
    int unsigned rot, word;
    rot  = ((l << 1) | (l >> 15)) & 16'hFFFF;
    word = ((l << 16) | l) ^ rot;
    return word % (1 << DW);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pre_idx = 0; m_run_idx = 0; m_win = 0;
    m_count = '0;
    for (int c = 0; c < NCH; c++) begin
      m_lfsr[c] = c + 1;
      m_dummy[c] = 1'b0; m_dummy_ok[c] = 1'b1;
      m_pwr[c] = 1'b0;   m_opt[c] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    int unsigned dsat;
    bit pre_go, act;
    dsat   = (duty_in > 16) ? 16 : duty_in;
    pre_go = (m_mode == M_PRE) && !abort;
    act    = (m_mode == M_RUN) && !abort && ((m_run_idx % 16) < dsat);
    for (int c = 0; c < NCH; c++) begin
      bit en, we;
      int unsigned a;
      en = (pre_go || act) && m_pwr[c];
      we = en && (pre_go || m_opt[c]);
      a  = (m_mode == M_PRE) ? m_pre_idx : (m_lfsr[c] % DEPTH);
      m_dummy[c]    = (m_dout[c] == (1 << DW) - 1);
      m_dummy_ok[c] = m_dout_ok[c];
      if (en) begin
        m_dout[c]    = m_mem[c][a];
        m_dout_ok[c] = m_mem_ok[c][a];
        if (we) begin
          m_mem[c][a]    = model_data(m_lfsr[c]);
          m_mem_ok[c][a] = 1'b1;
        end
      end
      if (m_mode == M_PRE || m_mode == M_RUN) m_lfsr[c] = model_lfsr(m_lfsr[c]);
    end
    if (act && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    case (m_mode)
      M_IDLE: if (start && !abort) begin
        m_count   = '0;
        m_win     = (window_cycles == 0) ? 1 : window_cycles;
        m_pre_idx = 0;
        m_run_idx = 0;
        m_mode    = (PRELOAD != 0) ? M_PRE : M_RUN;
      end
      M_PRE: begin
        if (abort)                       m_mode = M_IDLE;
        else if (m_pre_idx == DEPTH - 1) begin m_mode = M_RUN; m_run_idx = 0; end
        else                             m_pre_idx++;
      end
      M_RUN: begin
        if (abort)                       m_mode = M_IDLE;
        else if (m_run_idx == m_win - 1) m_mode = M_DONE;
        else                             m_run_idx++;
      end
      default: m_mode = M_IDLE;
    endcase
    for (int c = 0; c < NCH; c++) begin
      m_pwr[c] = pwr_en_in[c];
      m_opt[c] = opt_en_in[c];
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] mask, expd;
    for (int c = 0; c < NCH; c++) begin
      mask[c] = m_dummy_ok[c];
      expd[c] = m_dummy[c];
    end
    check("busy",  32'(busy), 32'(m_mode == M_PRE || m_mode == M_RUN));
    check("done",  32'(done), 32'(m_mode == M_DONE));
    check("count", access_count, m_count);
    check("dummy", 32'(dummy_out & mask), 32'(expd & mask));
    check("lfsr0", 32'(dut.lfsr[0]), m_lfsr[0]);
    check("lfsrN", 32'(dut.lfsr[NCH-1]), m_lfsr[NCH-1]);
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns after it.
  task automatic tick();
    if (rstn) model_step();
    @(posedge clk100m);
    #1;
    compare_all();
  endtask

  task automatic wait_idle(output int busy_n, output int done_n, output int cyc);
    busy_n = 0; done_n = 0; cyc = 0;
    while (m_mode != M_IDLE && cyc < 400) begin
      tick();
      busy_n += int'(busy);
      done_n += int'(done);
      cyc++;
    end
    check("idle_budget", 32'(cyc < 400), 32'd1);
  endtask

  // Directed window with closed-form expectations.
  task automatic run_window(input int d, input int w, input bit chk_seed);
    int busy_n, done_n, cyc, dsat, weff, expc, ph;
    int unsigned l;
    duty_in = 5'(d); window_cycles = 32'(w);
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(busy_n, done_n, cyc);
    busy_n += 1;  // the cycle sampled right after the start edge was busy
    dsat = (d > 16) ? 16 : d;
    weff = (w == 0) ? 1 : w;
    ph   = weff % 16;
    expc = (weff / 16) * dsat + ((ph < dsat) ? ph : dsat);
    check("win_busy_len", busy_n, DEPTH + weff);
    check("win_done_pulses", done_n, 1);
    check("win_count", access_count, expc);
    if (chk_seed) begin
      l = 1;
      for (int s = 0; s < DEPTH + weff; s++) l = model_lfsr(l);
      check("win_lfsr_steps", 32'(dut.lfsr[0]), l);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, cyc;
    for (int c = 0; c < NCH; c++) begin
      m_dout[c] = 0; m_dout_ok[c] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin m_mem[c][a] = 0; m_mem_ok[c][a] = 1'b0; end
    end
    model_reset();
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Directed windows, all channels on in write mode.
    pwr_en_in = '1; opt_en_in = '1;
    tick();
    run_window(16, 10, 1'b1);
    run_window(4, 32, 1'b0);
    run_window(31, 20, 1'b0);
    run_window(16, 0, 1'b0);
    run_window(0, 16, 1'b0);
    opt_en_in = '0;
    run_window(9, 37, 1'b0);

    // Abort on RUN cycle 5 of 100, then restart.
    opt_en_in = '1;
    duty_in = 5'd16; window_cycles = 32'd100;
    start = 1'b1; tick(); start = 1'b0;
    repeat (DEPTH + 5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_count", access_count, 32'd5);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_count", access_count, 32'd0);
    wait_idle(busy_n, done_n, cyc);
    check("restart_done", done_n, 1);

    // Reset in the middle of RUN, then a clean window.
    duty_in = 5'd16; window_cycles = 32'd50;
    start = 1'b1; tick(); start = 1'b0;
    repeat (DEPTH + 8) tick();
    rstn = 1'b0;
    #1;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_count", access_count, 32'd0);
    check("rst_dummy", 32'(dummy_out), 32'd0);
    model_reset();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    run_window(8, 24, 1'b0);

    // Randomised windows with live enable, duty, start and abort activity.
    for (int k = 0; k < 40; k++) begin
      duty_in = 5'($urandom_range(0, 31));
      window_cycles = 32'($urandom_range(0, 40));
      start = 1'b1;
      abort = ($urandom_range(0, 7) == 0);
      tick();
      start = 1'b0; abort = 1'b0;
      cyc = 0;
      while (m_mode != M_IDLE && cyc < 400) begin
        pwr_en_in = NCH'($urandom);
        opt_en_in = NCH'($urandom);
        start = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 60) == 0);
        if ($urandom_range(0, 15) == 0) duty_in = 5'($urandom_range(0, 31));
        tick();
        cyc++;
      end
      start = 1'b0; abort = 1'b0;
      check("rand_budget", 32'(cyc < 400), 32'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwr_harness_sram_gen.md
Name: pwr_harness_sram_gen

Overview:
- Parametrised power-estimation harness: NCH independent single-port SRAM channels, each driven by its own LFSR stimulus, each gated by per-channel power/operation enables.
- Adds a run controller over a fixed stimulus loop: optional preload pass, measured activity window of programmable length, programmable access duty cycle, and an access counter.
- Sits under the top-level power-measurement wrapper; host logic starts a window and reads the access count while the board-level power is measured.

Parameters:
- NCH, 32, channel count (1..65535).
- AW, 10, RAM address width per channel (1..16); depth 2^AW.
- DW, 18, RAM data width per channel (1..32).
- PRELOAD, 1, 1 = write every address once before RUN; 0 = skip the preload pass.

Ports:
- clk100m  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- pwr_en_in  in  NCH  per-channel RAM enable request.
- opt_en_in  in  NCH  per-channel write-mode request; write only when pwr_en is also set.
- duty_in  in  5  access duty in sixteenths; values above 16 saturate to 16.
- window_cycles  in  32  RUN length in cycles; sampled on start.
- start  in  1  begins a window from IDLE.
- abort  in  1  synchronous abort to IDLE.
- busy  out  1  high in PRELOAD or RUN.
- done  out  1  one-cycle pulse when RUN completes normally.
- access_count  out  32  RUN cycles with access strobe high.
- dummy_out  out  NCH  per-channel AND-reduction of read data, registered.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on clk100m/rstn.
- Reset values:
  - state IDLE; busy 0, done 0; access_count 0; dummy_out 0.
  - pwr_en_q/opt_en_q 0; all counters 0; lfsr[i] = i+1.
  - RAM contents are not reset.
- Input sampling: pwr_en_in/opt_en_in are registered every cycle in all states (1-cycle stage). Mid-run changes are legal and take effect 1 cycle later.
- LFSR per channel:
  - 16-bit; next = {l[0]^l[2]^l[3]^l[5], l[15:1]}.
  - Advances only in PRELOAD and RUN; holds in IDLE/DONE.
  - Never reseeded except by reset.
- Address and data:
  - RUN address = lfsr[AW-1:0].
  - Data = DW LSBs of {lfsr,lfsr} ^ {16'h0, lfsr rotated left by 1}, truncated to DW.
- Per-channel RAM: inferred synchronous single-port.
  - When en: read-first; douta updates the cycle after en.
  - When !en: douta holds.
- FSM states and transitions:
  - IDLE:
    - start && !abort: clear access_count; latch win = max(window_cycles,1).
    - Go to PRELOAD if PRELOAD=1, else RUN.
  - PRELOAD:
    - addr = pcnt (0..2^AW-1); en = we = pwr_en_q[i]; data from LFSR.
    - After pcnt = 2^AW-1, go to RUN; duration exactly 2^AW cycles.
  - RUN:
    - duty counter dcnt (4-bit, wraps 15->0, cleared on RUN entry).
    - act = (dcnt < duty_sat), where duty_sat = min(duty_in,16).
    - en[i] = act & pwr_en_q[i]; we[i] = en[i] & opt_en_q[i].
    - access_count += act, saturating at 32'hFFFF_FFFF.
    - rcnt counts RUN cycles; after win cycles, go to DONE.
  - DONE: done = 1 for one cycle; go to IDLE.
- start while busy is ignored; start during DONE is ignored.
- abort in PRELOAD/RUN: next state IDLE, no done pulse, access_count retained. abort in IDLE suppresses start.
- dummy_out[i] <= &douta[i] every cycle. Latency from access cycle to dummy_out is 2 cycles.
- duty_sat = 0: no RAM access in RUN, but LFSRs still advance and the window still completes.
- Reset asserted mid-operation: immediate return to reset values; done is not pulsed.

Test Plan:
- Reset release, PRELOAD=0, start, window_cycles=10, duty_in=16, pwr_en_in all 1 -> busy high 10 cycles, done pulses once, access_count=10, lfsr[0] after window = 10th LFSR step from seed 1.
- window_cycles=32, duty_in=4 -> access_count=8; en asserted on RUN cycles 0-3 and 16-19 only.
- PRELOAD=1, AW=4, opt_en all 1, window 1 -> PRELOAD lasts 16 cycles, then RUN 1 cycle; each address 0..15 written once.
- Write value with douta all-ones at the addressed word, then read it -> dummy_out[ch]=1 exactly 2 cycles after the read access cycle; pwr_en_in[ch]=0 -> douta of that channel frozen.
- Abort at RUN cycle 5 of 100 -> busy 0 next cycle, no done, access_count=5 (duty 16); start again -> count restarts at 0.
- rstn low mid-RUN -> outputs 0 asynchronously; duty_in=31 -> behaves as 16; window_cycles=0 -> RUN 1 cycle.
